// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths, FIFO sizing and byte type
//
// Purpose: common constants for the UART receive path so the receiver and its
//          buffer agree on data width and buffer depth.
// Contents: UART_WIDTH, RX_FIFO_DEPTH_LOG2, uart_byte_t.
package uart_pkg;
  localparam int UART_WIDTH         = 8;
  localparam int RX_FIFO_DEPTH_LOG2 = 4;

  typedef logic [UART_WIDTH-1:0] uart_byte_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - DEPTH x WIDTH register array, one write port, async read
//
// Purpose: storage for the receive FIFO; no reset, contents are qualified by the
//          owner's count.
// Ports:
//   clock  in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
module sync_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO draining uart_rx into a first-word-fall-through read port
//
// Purpose: takes each byte uart_rx reports with a one-cycle rx_read_en ack, buffers
//          it, and presents the head byte to the CPU with status flags. Bytes arriving
//          while full are acknowledged and dropped, raising sticky overflow.
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   rx_ready, rx_data   from uart_rx (data_ready, data_out)
//   rx_read_en          ack pulse to uart_rx
//   read_en             CPU pop request
//   data_out/data_valid head byte and non-empty flag
//   full, count         occupancy status
//   overflow            sticky drop flag; clear_overflow clears it
// Configuration: UART_RX_FIFO_IRQ_EN adds irq_threshold input and registered irq output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH      = UART_WIDTH,
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [WIDTH-1:0]      rx_data,
  output logic                  rx_read_en,
  input  logic                  read_en,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clear_overflow
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  input  logic [DEPTH_LOG2:0]   irq_threshold,
  output logic                  irq
`endif
);
  localparam logic [DEPTH_LOG2:0] C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_rx_read_en;
  logic                  r_overflow;

  logic                  w_capture;
  logic                  w_pop;
  logic                  w_space;
  logic                  w_push;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_count_next;
  logic                  w_overflow_next;

  // The ack cycle is a lockout: uart_rx still shows data_ready while it reacts
  // to our pulse, so the same byte must not be captured twice.
  assign w_capture = rx_ready & ~r_rx_read_en;
  assign w_pop     = read_en & (r_count != '0);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_space   = (r_count != C_DEPTH) | w_pop;
  assign w_push    = w_capture & w_space;
  assign w_drop    = w_capture & ~w_space;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  assign w_overflow_next = w_drop | (r_overflow & ~clear_overflow);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rx_read_en <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_rx_read_en <= w_capture;
      r_count      <= w_count_next;
      r_overflow   <= w_overflow_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic r_irq;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_count_next >= irq_threshold) | w_overflow_next;
    end
  end

  assign irq = r_irq;
`endif

  sync_fifo_mem #(
    .WIDTH  (WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clock (clock),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (rx_data),
    .raddr (r_rd_ptr),
    .rdata (data_out)
  );

  assign rx_read_en = r_rx_read_en;
  assign data_valid = (r_count != '0);
  assign full       = (r_count == C_DEPTH);
  assign count      = r_count;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DL2 = RX_FIFO_DEPTH_LOG2;

  logic         clock = 1'b0;
  logic         reset;
  logic         rx_ready;
  uart_byte_t   rx_data;
  logic         rx_read_en;
  logic         read_en;
  uart_byte_t   data_out;
  logic         data_valid;
  logic         full;
  logic [DL2:0] count;
  logic         overflow;
  logic         clear_overflow;
`ifdef UART_RX_FIFO_IRQ_EN
  logic [DL2:0] irq_threshold;
  logic         irq;
`endif

  uart_rx_fifo dut (
    .clock          (clock),
    .reset          (reset),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .rx_read_en     (rx_read_en),
    .read_en        (read_en),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .full           (full),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    .irq_threshold  (irq_threshold),
    .irq            (irq)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  uart_byte_t sb_q[$];

  typedef struct {
    logic         rdy;
    uart_byte_t   d;
    logic         ren;
    logic         exp_ack;
    logic [DL2:0] exp_cnt;
    bit           push;
    bit           pop;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_head(input string name);
    if (sb_q.size() == 0) begin
      check({name, "_valid"}, 32'(data_valid), 32'd0);
    end else begin
      check({name, "_valid"}, 32'(data_valid), 32'd1);
      check({name, "_data"}, 32'(data_out), 32'(sb_q[0]));
    end
  endtask

  // Behaves like uart_rx: data_ready held until one cycle after the ack.
  task automatic send_byte(input uart_byte_t b, input bit pop, input bit clr, input bit accept);
    rx_ready       = 1'b1;
    rx_data        = b;
    read_en        = pop;
    clear_overflow = clr;
    cycle();
    if (pop && sb_q.size() > 0) void'(sb_q.pop_front());
    if (accept) sb_q.push_back(b);
    check("ack_pulse", 32'(rx_read_en), 32'd1);
    read_en        = 1'b0;
    clear_overflow = 1'b0;
    cycle();
    check("ack_lockout", 32'(rx_read_en), 32'd0);
    check("count_after_send", 32'(count), 32'(sb_q.size()));
    rx_ready = 1'b0;
  endtask

  task automatic pop_one();
    check_head("pop_head");
    read_en = 1'b1;
    cycle();
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    read_en = 1'b0;
    check("count_after_pop", 32'(count), 32'(sb_q.size()));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 8'h55, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'h55, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 8'hA2, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1};

    reset          = 1'b1;
    rx_ready       = 1'b0;
    rx_data        = 8'h00;
    read_en        = 1'b0;
    clear_overflow = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
    irq_threshold  = 5'd3;
`endif
    @(negedge clock);
    cycle();
    cycle();
    reset = 1'b0;

    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_ack", 32'(rx_read_en), 32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif

    // Single byte, empty-pop ignore, and push+pop at count 1.
    for (int i = 0; i < 12; i++) begin
      rx_ready = tbl[i].rdy;
      rx_data  = tbl[i].d;
      read_en  = tbl[i].ren;
      cycle();
      if (tbl[i].pop && sb_q.size() > 0) void'(sb_q.pop_front());
      if (tbl[i].push) sb_q.push_back(tbl[i].d);
      check($sformatf("vec%0d_ack", i), 32'(rx_read_en), 32'(tbl[i].exp_ack));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
      check($sformatf("vec%0d_full", i), 32'(full), 32'd0);
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
      check_head($sformatf("vec%0d_head", i));
    end
    rx_ready = 1'b0;
    read_en  = 1'b0;

    // Fill to 16 entries.
    for (int i = 1; i <= 16; i++) begin
      send_byte(uart_byte_t'(i), 1'b0, 1'b0, 1'b1);
      if (i == 15) check("full_at_15", 32'(full), 32'd0);
    end
    check("full_at_16", 32'(full), 32'd1);
    check("count_16", 32'(count), 32'd16);
    check_head("head_01");

    // Byte while full: acked and dropped.
    send_byte(8'hAA, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check_head("head_after_drop");
    clear_overflow = 1'b1;
    cycle();
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Drop and clear in the same cycle: set wins.
    send_byte(8'hCC, 1'b0, 1'b1, 1'b0);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    cycle();
    clear_overflow = 1'b0;
    check("ovf_cleared2", 32'(overflow), 32'd0);

    // Full with simultaneous pop: accepted as 16th entry.
    send_byte(8'hBB, 1'b1, 1'b0, 1'b1);
    check("bb_no_ovf", 32'(overflow), 32'd0);
    check("bb_full", 32'(full), 32'd1);

    for (int i = 0; i < 16; i++) pop_one();
    check("drained_valid", 32'(data_valid), 32'd0);
    check("drained_count", 32'(count), 32'd0);

    // Reset at count 5 with a capture pending.
    for (int i = 0; i < 5; i++) send_byte(uart_byte_t'(8'h30 + i), 1'b0, 1'b0, 1'b1);
    check("count_5", 32'(count), 32'd5);
    reset    = 1'b1;
    rx_ready = 1'b1;
    rx_data  = 8'h77;
    cycle();
    sb_q.delete();
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_ack", 32'(rx_read_en), 32'd0);
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    reset    = 1'b0;
    rx_ready = 1'b0;
    cycle();

    // Post-reset pointers restart cleanly.
    send_byte(8'h5A, 1'b0, 1'b0, 1'b1);
    check_head("post_rst_head");
    pop_one();

`ifdef UART_RX_FIFO_IRQ_EN
    send_byte(8'h61, 1'b0, 1'b0, 1'b1);
    send_byte(8'h62, 1'b0, 1'b0, 1'b1);
    check("irq_below", 32'(irq), 32'd0);
    rx_ready = 1'b1;
    rx_data  = 8'h63;
    cycle();
    sb_q.push_back(8'h63);
    check("irq_at_thr", 32'(irq), 32'd1);
    cycle();
    rx_ready = 1'b0;
    pop_one();
    check("irq_after_pop", 32'(irq), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
